// File: rtl/ibex_rf_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package ibex_rf_wb_pkg;

    localparam int unsigned RegAddrW     = 5;
    localparam int unsigned WbDataWidth  = 32;

    // One register-file write request.
    typedef struct packed {
        logic [RegAddrW-1:0]    waddr;
        logic [WbDataWidth-1:0] wdata;
    } wb_req_t;

    // RV32E only implements x0..x15, so any address with bit 4 set is illegal.
    function automatic logic is_legal_waddr(input logic [RegAddrW-1:0] addr, input logic rv32e);
        return !(rv32e && addr[4]);
    endfunction

endpackage

// File: rtl/ibex_rf_write_arbiter_if.sv
// Result sources (execute with handshake, LSU without) and the RF write port.
interface ibex_rf_write_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    import ibex_rf_wb_pkg::*;

    logic                 ex_valid_i;
    logic                 ex_ready_o;
    logic [RegAddrW-1:0]  ex_waddr_i;
    logic [DataWidth-1:0] ex_wdata_i;
    logic                 lsu_rvalid_i;
    logic [RegAddrW-1:0]  lsu_waddr_i;
    logic [DataWidth-1:0] lsu_rdata_i;
    logic                 rf_we_o;
    logic [RegAddrW-1:0]  rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_rvalid_i, lsu_waddr_i, lsu_rdata_i,
        input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_rvalid_i, lsu_waddr_i, lsu_rdata_i,
        output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface

// File: rtl/ibex_rf_write_arbiter_fifo.sv
// Circular FIFO holding displaced execute results; exposes per-slot
// valid/address so the owner can run hazard compares against it.
module ibex_rf_wb_fifo
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [RegAddrW-1:0]          push_waddr_i,
    input  logic [DataWidth-1:0]         push_wdata_i,
    input  logic                         pop_i,
    output logic [RegAddrW-1:0]          head_waddr_o,
    output logic [DataWidth-1:0]         head_wdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [2:0]                   count_o,
    output logic [Depth-1:0]             entry_valid_o,
    output logic [Depth*RegAddrW-1:0]    entry_waddr_o
);

    localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [2:0]      DepthCnt = 3'(Depth);

    logic [RegAddrW-1:0]  waddr_mem_r [Depth];
    logic [DataWidth-1:0] wdata_mem_r [Depth];
    logic [Depth-1:0]     valid_r;
    logic [Depth-1:0]     valid_next_s;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [PtrW-1:0]      wr_ptr_r;
    logic [2:0]           count_r;
    logic [2:0]           count_next_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    // Next slot-valid vector and occupancy from this cycle's push/pop.
    always_comb begin
        valid_next_s = valid_r;
        for (int i = 0; i < int'(Depth); i++) begin
            valid_next_s[i] = (push_i && (wr_ptr_r == PtrW'(i))) ? 1'b1 :
                              (pop_i  && (rd_ptr_r == PtrW'(i))) ? 1'b0 : valid_r[i];
        end
        case ({push_i, pop_i})
            2'b10:   count_next_s = count_r + 3'd1;
            2'b01:   count_next_s = count_r - 3'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy and slot-valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r <= {PtrW{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            count_r  <= 3'd0;
            valid_r  <= {Depth{1'b0}};
        end else begin
            if (push_i) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_i)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_next_s;
            valid_r <= valid_next_s;
        end
    end

    // Payload storage; contents are only meaningful where valid_r is set.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            waddr_mem_r[wr_ptr_r] <= push_waddr_i;
            wdata_mem_r[wr_ptr_r] <= push_wdata_i;
        end
    end

    // Flatten slot addresses for the hazard compare.
    always_comb begin
        entry_waddr_o = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            entry_waddr_o[i*RegAddrW +: RegAddrW] = waddr_mem_r[i];
        end
    end

    assign head_waddr_o  = waddr_mem_r[rd_ptr_r];
    assign head_wdata_o  = wdata_mem_r[rd_ptr_r];
    assign full_o        = (count_r == DepthCnt);
    assign empty_o       = (count_r == 3'd0);
    assign count_o       = count_r;
    assign entry_valid_o = valid_r;

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Merges execute results and LSU load data onto the single RF write port,
// buffering displaced execute results and reporting read-after-write hazards.
module ibex_rf_write_arbiter
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ibex_rf_write_arbiter_if.slave bus,
    input  logic [RegAddrW-1:0]    raddr_a_i,
    input  logic [RegAddrW-1:0]    raddr_b_i,
    output logic                   hazard_a_o,
    output logic                   hazard_b_o,
    output logic [2:0]             fifo_count_o,
    output logic                   err_o
);

    logic                          fifo_full_s;
    logic                          fifo_empty_s;
    logic [2:0]                    fifo_count_s;
    logic [RegAddrW-1:0]           head_waddr_s;
    logic [DataWidth-1:0]          head_wdata_s;
    logic [FifoDepth-1:0]          entry_valid_s;
    logic [FifoDepth*RegAddrW-1:0] entry_waddr_s;

    logic                 ex_fire_s, ex_legal_s, ex_keep_s;
    logic                 lsu_legal_s, lsu_keep_s;
    logic                 err_next_s;
    logic                 push_s, pop_s;
    logic                 we_next_s;
    logic [RegAddrW-1:0]  waddr_next_s;
    logic [DataWidth-1:0] wdata_next_s;
    logic                 hit_a_s, hit_b_s;

    logic                 rf_we_r;
    logic [RegAddrW-1:0]  rf_waddr_r;
    logic [DataWidth-1:0] rf_wdata_r;
    logic                 err_r;

    ibex_rf_wb_fifo #(
        .DataWidth (DataWidth),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push_s),
        .push_waddr_i  (bus.ex_waddr_i),
        .push_wdata_i  (bus.ex_wdata_i),
        .pop_i         (pop_s),
        .head_waddr_o  (head_waddr_s),
        .head_wdata_o  (head_wdata_s),
        .full_o        (fifo_full_s),
        .empty_o       (fifo_empty_s),
        .count_o       (fifo_count_s),
        .entry_valid_o (entry_valid_s),
        .entry_waddr_o (entry_waddr_s)
    );

    // Ready depends on registered occupancy only, so a same-cycle pop never raises it.
    assign bus.ex_ready_o = !rst_i && !fifo_full_s;

    // Filtering: x0 writes vanish silently, RV32E out-of-range writes vanish and flag err.
    assign ex_fire_s   = bus.ex_valid_i && bus.ex_ready_o;
    assign ex_legal_s  = is_legal_waddr(bus.ex_waddr_i, RV32E);
    assign lsu_legal_s = is_legal_waddr(bus.lsu_waddr_i, RV32E);
    assign ex_keep_s   = ex_fire_s && ex_legal_s && (bus.ex_waddr_i != 5'd0);
    assign lsu_keep_s  = bus.lsu_rvalid_i && lsu_legal_s && (bus.lsu_waddr_i != 5'd0);
    assign err_next_s  = (ex_fire_s && !ex_legal_s) || (bus.lsu_rvalid_i && !lsu_legal_s);

    // Port arbitration: load first, then FIFO head, then bypass only when the FIFO is empty.
    always_comb begin
        we_next_s    = 1'b0;
        waddr_next_s = rf_waddr_r;
        wdata_next_s = rf_wdata_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        if (lsu_keep_s) begin
            we_next_s    = 1'b1;
            waddr_next_s = bus.lsu_waddr_i;
            wdata_next_s = bus.lsu_rdata_i;
            push_s       = ex_keep_s;
        end else if (!fifo_empty_s) begin
            we_next_s    = 1'b1;
            waddr_next_s = head_waddr_s;
            wdata_next_s = head_wdata_s;
            pop_s        = 1'b1;
            push_s       = ex_keep_s;
        end else if (ex_keep_s) begin
            we_next_s    = 1'b1;
            waddr_next_s = bus.ex_waddr_i;
            wdata_next_s = bus.ex_wdata_i;
        end else begin
            we_next_s    = 1'b0;
        end
    end

    // Registered write port and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= '0;
            err_r      <= 1'b0;
        end else begin
            rf_we_r    <= we_next_s;
            rf_waddr_r <= waddr_next_s;
            rf_wdata_r <= wdata_next_s;
            err_r      <= err_next_s;
        end
    end

    // Hazard match against buffered entries; the in-flight RF write is added below.
    always_comb begin
        hit_a_s = 1'b0;
        hit_b_s = 1'b0;
        for (int i = 0; i < int'(FifoDepth); i++) begin
            hit_a_s = hit_a_s || (entry_valid_s[i] && (entry_waddr_s[i*RegAddrW +: RegAddrW] == raddr_a_i));
            hit_b_s = hit_b_s || (entry_valid_s[i] && (entry_waddr_s[i*RegAddrW +: RegAddrW] == raddr_b_i));
        end
    end

    assign hazard_a_o = (raddr_a_i != 5'd0) && (hit_a_s || (rf_we_r && (rf_waddr_r == raddr_a_i)));
    assign hazard_b_o = (raddr_b_i != 5'd0) && (hit_b_s || (rf_we_r && (rf_waddr_r == raddr_b_i)));

    assign bus.rf_we_o    = rf_we_r;
    assign bus.rf_waddr_o = rf_waddr_r;
    assign bus.rf_wdata_o = rf_wdata_r;
    assign fifo_count_o   = fifo_count_s;
    assign err_o          = err_r;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Scoreboard bench: expected RF writes are queued as stimulus is applied and
// popped by a monitor whenever the write port fires.
module tb_ibex_rf_write_arbiter;
    import ibex_rf_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_rf_write_arbiter_if #(.DataWidth(32)) ifa ();
    ibex_rf_write_arbiter_if #(.DataWidth(32)) ifb ();

    logic [4:0] raddr_a_a, raddr_b_a, raddr_a_b, raddr_b_b;
    logic       haz_a_a, haz_b_a, haz_a_b, haz_b_b;
    logic [2:0] cnt_a, cnt_b;
    logic       err_a, err_b;

    ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(1'b0), .FifoDepth(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa),
        .raddr_a_i(raddr_a_a), .raddr_b_i(raddr_b_a),
        .hazard_a_o(haz_a_a), .hazard_b_o(haz_b_a),
        .fifo_count_o(cnt_a), .err_o(err_a)
    );

    ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(1'b1), .FifoDepth(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb),
        .raddr_a_i(raddr_a_b), .raddr_b_i(raddr_b_b),
        .hazard_a_o(haz_a_b), .hazard_b_o(haz_b_b),
        .fifo_count_o(cnt_b), .err_o(err_b)
    );

    wb_req_t qa[$];
    wb_req_t qb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_req_t req(input logic [4:0] a, input logic [31:0] d);
        wb_req_t r;
        r.waddr = a;
        r.wdata = d;
        return r;
    endfunction

    // Monitor for instance A: every write must match the next expected one.
    always @(negedge clk) begin
        if (ifa.rf_we_o === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_we", 32'd1, 32'd0);
            end else begin
                wb_req_t e;
                e = qa.pop_front();
                check("a_wr_addr", 32'(ifa.rf_waddr_o), 32'(e.waddr));
                check("a_wr_data", ifa.rf_wdata_o, e.wdata);
            end
        end
    end

    // Monitor for instance B (RV32E).
    always @(negedge clk) begin
        if (ifb.rf_we_o === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_we", 32'd1, 32'd0);
            end else begin
                wb_req_t e;
                e = qb.pop_front();
                check("b_wr_addr", 32'(ifb.rf_waddr_o), 32'(e.waddr));
                check("b_wr_data", ifb.rf_wdata_o, e.wdata);
            end
        end
    end

    task automatic idle_a();
        ifa.ex_valid_i   = 1'b0;
        ifa.ex_waddr_i   = 5'd0;
        ifa.ex_wdata_i   = 32'd0;
        ifa.lsu_rvalid_i = 1'b0;
        ifa.lsu_waddr_i  = 5'd0;
        ifa.lsu_rdata_i  = 32'd0;
    endtask

    task automatic idle_b();
        ifb.ex_valid_i   = 1'b0;
        ifb.ex_waddr_i   = 5'd0;
        ifb.ex_wdata_i   = 32'd0;
        ifb.lsu_rvalid_i = 1'b0;
        ifb.lsu_waddr_i  = 5'd0;
        ifb.lsu_rdata_i  = 32'd0;
    endtask

    initial begin
        int   idx;
        logic acc;
        idle_a();
        idle_b();
        raddr_a_a = 5'd0; raddr_b_a = 5'd0;
        raddr_a_b = 5'd0; raddr_b_b = 5'd0;

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_we",    32'(ifa.rf_we_o),    32'd0);
        check("rst_waddr", 32'(ifa.rf_waddr_o), 32'd0);
        check("rst_wdata", ifa.rf_wdata_o,      32'd0);
        check("rst_count", 32'(cnt_a),          32'd0);
        check("rst_ready", 32'(ifa.ex_ready_o), 32'd0);
        check("rst_err",   32'(err_a),          32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ifa.ex_ready_o), 32'd1);
        cyc();

        // Single execute write bypasses to the port
        ifa.ex_valid_i = 1'b1; ifa.ex_waddr_i = 5'd5; ifa.ex_wdata_i = 32'hDEADBEEF;
        qa.push_back(req(5'd5, 32'hDEADBEEF));
        cyc();
        idle_a();
        check("t1_we",    32'(ifa.rf_we_o),    32'd1);
        check("t1_waddr", 32'(ifa.rf_waddr_o), 32'd5);
        check("t1_wdata", ifa.rf_wdata_o,      32'hDEADBEEF);
        check("t1_count", 32'(cnt_a),          32'd0);
        cyc();

        // Load and execute in the same cycle: load first, ex buffered
        ifa.lsu_rvalid_i = 1'b1; ifa.lsu_waddr_i = 5'd7; ifa.lsu_rdata_i = 32'h11;
        ifa.ex_valid_i   = 1'b1; ifa.ex_waddr_i  = 5'd3; ifa.ex_wdata_i  = 32'h22;
        raddr_a_a = 5'd3;
        qa.push_back(req(5'd7, 32'h11));
        qa.push_back(req(5'd3, 32'h22));
        cyc();
        idle_a();
        check("t2_waddr_load", 32'(ifa.rf_waddr_o), 32'd7);
        check("t2_count1",     32'(cnt_a),          32'd1);
        check("t2_haz_fifo",   32'(haz_a_a),        32'd1);
        cyc();
        check("t2_waddr_buf",  32'(ifa.rf_waddr_o), 32'd3);
        check("t2_count0",     32'(cnt_a),          32'd0);
        check("t2_haz_port",   32'(haz_a_a),        32'd1);
        cyc();
        check("t2_haz_clear",  32'(haz_a_a),        32'd0);
        raddr_a_a = 5'd0;

        // x0 on both sources: nothing written, buffered or flagged
        ifa.ex_valid_i = 1'b1; ifa.ex_waddr_i = 5'd0; ifa.ex_wdata_i = 32'hFFFF;
        ifa.lsu_rvalid_i = 1'b1; ifa.lsu_waddr_i = 5'd0; ifa.lsu_rdata_i = 32'h1234;
        raddr_b_a = 5'd0;
        cyc();
        idle_a();
        check("x0_we",    32'(ifa.rf_we_o), 32'd0);
        check("x0_count", 32'(cnt_a),       32'd0);
        check("x0_err",   32'(err_a),       32'd0);
        check("x0_haz_b", 32'(haz_b_a),     32'd0);
        cyc();

        // RV32E: out-of-range writes discarded with an err pulse
        ifb.ex_valid_i = 1'b1; ifb.ex_waddr_i = 5'd20; ifb.ex_wdata_i = 32'h5;
        cyc();
        idle_b();
        check("e_we",       32'(ifb.rf_we_o), 32'd0);
        check("e_err",      32'(err_b),       32'd1);
        cyc();
        check("e_err_drop", 32'(err_b),       32'd0);
        ifb.ex_valid_i = 1'b1; ifb.ex_waddr_i = 5'd20; ifb.ex_wdata_i = 32'h6;
        ifb.lsu_rvalid_i = 1'b1; ifb.lsu_waddr_i = 5'd17; ifb.lsu_rdata_i = 32'h7;
        cyc();
        idle_b();
        check("e_both_err", 32'(err_b),       32'd1);
        check("e_both_we",  32'(ifb.rf_we_o), 32'd0);
        cyc();
        check("e_both_one", 32'(err_b),       32'd0);
        ifb.ex_valid_i = 1'b1; ifb.ex_waddr_i = 5'd15; ifb.ex_wdata_i = 32'h77;
        qb.push_back(req(5'd15, 32'h77));
        cyc();
        idle_b();
        check("e_x15_we",    32'(ifb.rf_we_o),    32'd1);
        check("e_x15_waddr", 32'(ifb.rf_waddr_o), 32'd15);
        check("e_x15_err",   32'(err_b),          32'd0);
        cyc();
        check("e_q_empty",   32'(qb.size()),      32'd0);

        // Back-to-back loads with ex held: backpressure then in-order drain
        qa.push_back(req(5'd10, 32'hA0));
        qa.push_back(req(5'd11, 32'hA1));
        qa.push_back(req(5'd12, 32'hA2));
        qa.push_back(req(5'd1,  32'h101));
        qa.push_back(req(5'd2,  32'h102));
        qa.push_back(req(5'd3,  32'h103));
        idx = 1;
        for (int i = 0; i < 12; i++) begin
            ifa.lsu_rvalid_i = (i < 3);
            ifa.lsu_waddr_i  = 5'(10 + i);
            ifa.lsu_rdata_i  = 32'(32'hA0 + i);
            ifa.ex_valid_i   = (idx <= 3);
            ifa.ex_waddr_i   = 5'(idx);
            ifa.ex_wdata_i   = 32'(32'h100 + idx);
            if (i == 2) check("s_ready_full", 32'(ifa.ex_ready_o), 32'd0);
            if (i == 4) check("s_ready_back", 32'(ifa.ex_ready_o), 32'd1);
            check("s_count_max", 32'(cnt_a > 3'd2), 32'd0);
            acc = ifa.ex_valid_i && ifa.ex_ready_o;
            cyc();
            if (acc) idx++;
        end
        idle_a();
        check("s_all_accepted", 32'(idx),       32'd4);
        check("s_drained",      32'(qa.size()), 32'd0);
        check("s_count0",       32'(cnt_a),     32'd0);

        // Reset with two buffered entries discards them
        ifa.lsu_rvalid_i = 1'b1; ifa.lsu_waddr_i = 5'd20; ifa.lsu_rdata_i = 32'h200;
        ifa.ex_valid_i   = 1'b1; ifa.ex_waddr_i  = 5'd8;  ifa.ex_wdata_i  = 32'h300;
        qa.push_back(req(5'd20, 32'h200));
        cyc();
        ifa.lsu_rvalid_i = 1'b1; ifa.lsu_waddr_i = 5'd21; ifa.lsu_rdata_i = 32'h201;
        ifa.ex_valid_i   = 1'b1; ifa.ex_waddr_i  = 5'd9;  ifa.ex_wdata_i  = 32'h301;
        qa.push_back(req(5'd21, 32'h201));
        cyc();
        idle_a();
        check("r_count2", 32'(cnt_a), 32'd2);
        rst = 1'b1;
        #1;
        check("r_ready_in_rst", 32'(ifa.ex_ready_o), 32'd0);
        cyc();
        check("r_count0", 32'(cnt_a),          32'd0);
        check("r_we0",    32'(ifa.rf_we_o),    32'd0);
        check("r_ready0", 32'(ifa.ex_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("r_ready1", 32'(ifa.ex_ready_o), 32'd1);
        for (int i = 0; i < 6; i++) cyc();
        check("r_no_stale_write", 32'(qa.size()), 32'd0);
        check("r_count_idle",     32'(cnt_a),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
